core_load_ctrl: RTL and testbench

CORE_LOAD_CTRL -- requirements
Module: core_load_ctrl

---
 rtl/core_load_pkg.sv | 8 +
 rtl/core_load_ctrl_reset_stretch.sv | 28 ++
 rtl/core_load_ctrl.sv | 80 ++++++++
 tb/tb_core_load_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_load_pkg.sv
// core_load_pkg: shared state encoding and download index constants for core_load_ctrl.
package core_load_pkg;
  typedef enum logic [1:0] {LOAD, SETTLE, RUN} state_t;
  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;
  localparam int NUM_DIP = 3;
endpackage

// File: rtl/core_load_ctrl_reset_stretch.sv
// reset_stretch: settle counter plus the registered core reset it stretches.
// Ports: clk_sys/reset_n clock and sync active-low reset; clear forces the
// counter to 0 and hold high; start lets the counter run while hold is high;
// hold is the registered core reset; last flags the final settle cycle.
module reset_stretch #(
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic start,
  input  logic clear,
  output logic hold,
  output logic last
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  logic [CW-1:0] cnt;
  assign last = cnt == CW'(SETTLE_CYCLES - 1);
  // hold drops on the same edge the controller moves to RUN, since both use last.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || clear) begin
      cnt  <= '0;
      hold <= 1'b1;
    end else if (start && hold) begin
      if (last) hold <= 1'b0;
      else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/core_load_ctrl.sv
// core_load_ctrl: routes HPS download bytes to ROM/game-select/DIP targets and sequences core reset.
// Ports: clk_sys, reset_n (sync active-low); ioctl_download/wr/index/addr/dout
// from the HPS; user_reset from OSD/button; rom_wr/rom_addr/rom_data to the
// game ROM; mod_sel and sw latched config; core_reset, load_busy, rom_err status.
module core_load_ctrl
  import core_load_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4096,
  parameter int ROM_LIMIT     = 49152
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic        rom_wr,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [7:0]  mod_sel,
  output logic [23:0] sw,
  output logic        core_reset,
  output logic        load_busy,
  output logic        rom_err
);
  state_t state, nxt;
  logic dl_q, rise, qual, rom_hit, rom_bad, dip_hit, last;
  // dl_q resets low so a download already active at reset release counts as a rising edge.
  assign rise    = ioctl_download & ~dl_q;
  assign qual    = ioctl_wr & ioctl_download;
  assign rom_hit = qual && ioctl_index == IDX_ROM && ioctl_addr < 25'(ROM_LIMIT);
  assign rom_bad = qual && ioctl_index == IDX_ROM && ioctl_addr >= 25'(ROM_LIMIT);
  assign dip_hit = qual && ioctl_index == IDX_DIP && ioctl_addr[24:3] == '0 &&
                   ioctl_addr[2:0] < 3'(NUM_DIP);
  always_comb begin
    nxt = state;
    if (rise) nxt = LOAD;
    else if (state == LOAD) nxt = ioctl_download ? LOAD : SETTLE;
    else if (user_reset) nxt = SETTLE;
    else if (state == SETTLE && last) nxt = RUN;
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= SETTLE;
    else state <= nxt;
  end
  // The counter is held at 0 throughout LOAD so SETTLE always starts from 0.
  reset_stretch #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_stretch (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .start   (state == SETTLE),
    .clear   (rise || user_reset || state == LOAD),
    .hold    (core_reset),
    .last    (last)
  );
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dl_q      <= 1'b0;
      load_busy <= 1'b0;
      rom_wr    <= 1'b0;
      rom_addr  <= '0;
      rom_data  <= '0;
      rom_err   <= 1'b0;
      mod_sel   <= '0;
      sw        <= '1;
    end else begin
      dl_q      <= ioctl_download;
      load_busy <= nxt == LOAD;
      rom_wr    <= rom_hit;
      if (rom_hit) begin
        rom_addr <= ioctl_addr[15:0];
        rom_data <= ioctl_dout;
      end
      rom_err <= rom_bad | (rom_err & ~rise);
      if (qual && ioctl_index == IDX_MOD) mod_sel <= ioctl_dout;
      if (dip_hit) sw[{ioctl_addr[1:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end
endmodule

// File: tb/tb_core_load_ctrl.sv
// tb_core_load_ctrl: randomized self-checking bench for core_load_ctrl against a byte-routing model.
module tb_core_load_ctrl;
  localparam int N   = 4096;
  localparam int LIM = 49152;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        user_reset = 1'b0;
  logic        rom_wr, core_reset, load_busy, rom_err;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data, mod_sel;
  logic [23:0] sw;
  core_load_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .user_reset(user_reset), .rom_wr(rom_wr),
    .rom_addr(rom_addr), .rom_data(rom_data), .mod_sel(mod_sel), .sw(sw),
    .core_reset(core_reset), .load_busy(load_busy), .rom_err(rom_err)
  );
  always #5 clk_sys = ~clk_sys;
  typedef struct {int c; logic [15:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t got_q[$];
  int cyc_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0]  m_mod;
  logic [7:0]  m_sw [3];
  logic        m_err;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  always @(posedge clk_sys) cyc_n++;
  always @(posedge clk_sys) begin
    #1;
    if (rom_wr === 1'b1) got_q.push_back('{cyc_n, rom_addr, rom_data});
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 1000000", $time);
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask
  // Drives one byte for one cycle and updates the expected results from the routing rules.
  task automatic put_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    if (reset_n && ioctl_download) begin
      if (idx == 8'd0) begin
        if (a < 25'(LIM)) begin
          exp_q.push_back('{cyc_n + 1, a[15:0], d});
          m_addr = a[15:0];
          m_data = d;
        end else m_err = 1'b1;
      end else if (idx == 8'd1) m_mod = d;
      else if (idx == 8'd254 && a < 25'd3) m_sw[a[1:0]] = d;
    end
    tick;
    ioctl_wr = 1'b0;
  endtask
  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick;
    m_err = 1'b0;
  endtask
  task automatic end_dl;
    ioctl_download = 1'b0;
    tick;
  endtask
  task automatic test_reset;
    int n;
    m_mod = '0;
    m_sw = '{8'hFF, 8'hFF, 8'hFF};
    m_err = 1'b0;
    m_addr = '0;
    m_data = '0;
    reset_n = 1'b0;
    repeat (3) tick;
    n_chk++;
    if ({core_reset, load_busy, rom_wr, rom_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 1000", {core_reset, load_busy, rom_wr, rom_err});
    end
    n_chk++;
    if (rom_addr !== 16'h0 || rom_data !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_rom: got %h/%h required 0000/00", rom_addr, rom_data);
    end
    n_chk++;
    if (mod_sel !== 8'h00 || sw !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL reset_cfg: got %h/%h required 00/ffffff", mod_sel, sw);
    end
    reset_n = 1'b1;
    n = 0;
    while (core_reset === 1'b1 && n < 6000) begin
      n++;
      tick;
    end
    n_chk++;
    if (n != N) begin
      n_fail++;
      $display("FAIL reset_hold_len: got %0d cycles required %0d", n, N);
    end
    n_chk++;
    if (core_reset !== 1'b0 || load_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL run_after_reset: got core_reset=%b load_busy=%b required 0/0", core_reset, load_busy);
    end
  endtask
  task automatic test_rom;
    logic [7:0] idx;
    logic [24:0] a;
    int r;
    exp_q.delete();
    got_q.delete();
    start_dl(8'd0);
    n_chk++;
    if (load_busy !== 1'b1 || core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL rom_load_entry: got busy=%b core_reset=%b required 1/1", load_busy, core_reset);
    end
    put_byte(8'd0, 25'h0000, 8'hA5);
    put_byte(8'd0, 25'hBFFF, 8'h5A);
    put_byte(8'd0, 25'hC000, 8'h11);
    n_chk++;
    if (rom_wr !== 1'b0 || rom_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rom_limit: got rom_wr=%b rom_err=%b required 0/1", rom_wr, rom_err);
    end
    n_chk++;
    if (got_q.size() != 2) begin
      n_fail++;
      $display("FAIL rom_fixed_count: got %0d writes required 2", got_q.size());
    end
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 5);
      idx = r < 3 ? 8'd0 : r == 3 ? 8'd1 : r == 4 ? 8'd254 : 8'($urandom_range(2, 253));
      if (idx == 8'd0)
        a = $urandom_range(0, 3) == 0 ? 25'($urandom_range(LIM, 70000)) : 25'($urandom_range(0, LIM - 1));
      else a = 25'($urandom_range(0, 10));
      put_byte(idx, a, 8'($urandom));
      if ($urandom_range(0, 1) == 1) tick;
    end
    end_dl;
    n_chk++;
    if (load_busy !== 1'b0 || core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL rom_settle_entry: got busy=%b core_reset=%b required 0/1", load_busy, core_reset);
    end
    tick;
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rom_count: got %0d writes required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i].c != exp_q[i].c || got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d) begin
        n_fail++;
        $display("FAIL rom_write[%0d]: got cyc %0d %h=%h required cyc %0d %h=%h", i,
                 got_q[i].c, got_q[i].a, got_q[i].d, exp_q[i].c, exp_q[i].a, exp_q[i].d);
      end
    end
    n_chk++;
    if (rom_addr !== m_addr || rom_data !== m_data || rom_err !== m_err) begin
      n_fail++;
      $display("FAIL rom_hold: got %h/%h err=%b required %h/%h err=%b", rom_addr, rom_data, rom_err,
               m_addr, m_data, m_err);
    end
    n_chk++;
    if (mod_sel !== m_mod || sw !== {m_sw[2], m_sw[1], m_sw[0]}) begin
      n_fail++;
      $display("FAIL rom_random_cfg: got %h/%h required %h/%h", mod_sel, sw, m_mod, {m_sw[2], m_sw[1], m_sw[0]});
    end
  endtask
  task automatic test_regs;
    start_dl(8'd1);
    put_byte(8'd1, 25'($urandom_range(0, 100000)), 8'h03);
    put_byte(8'd1, 25'($urandom_range(0, 100000)), 8'h0C);
    end_dl;
    start_dl(8'd254);
    put_byte(8'd254, 25'd0, 8'hF0);
    put_byte(8'd254, 25'd1, 8'h0F);
    put_byte(8'd254, 25'd2, 8'h81);
    put_byte(8'd254, 25'd3, 8'h77);
    put_byte(8'd254, 25'd8, 8'h55);
    put_byte(8'd254, 25'h100001, 8'h66);
    end_dl;
    n_chk++;
    if (mod_sel !== 8'h0C || sw !== 24'h810FF0) begin
      n_fail++;
      $display("FAIL cfg_bytes: got %h/%h required 0c/810ff0", mod_sel, sw);
    end
    start_dl(8'd5);
    put_byte(8'd5, 25'd0, 8'hEE);
    end_dl;
    put_byte(8'd1, 25'd0, 8'h99);
    put_byte(8'd254, 25'd0, 8'h99);
    user_reset = 1'b1;
    tick;
    tick;
    user_reset = 1'b0;
    tick;
    n_chk++;
    if (mod_sel !== m_mod || sw !== {m_sw[2], m_sw[1], m_sw[0]} || core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_persist: got %h/%h core_reset=%b required %h/%h core_reset=1", mod_sel, sw,
               core_reset, m_mod, {m_sw[2], m_sw[1], m_sw[0]});
    end
  endtask
  task automatic test_user_reset;
    int n;
    logic dropped;
    start_dl(8'd0);
    put_byte(8'd0, 25'hFFFF, 8'h42);
    end_dl;
    n_chk++;
    if (rom_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ur_err_set: got %b required 1", rom_err);
    end
    dropped = 1'b0;
    repeat (2000) begin
      tick;
      if (core_reset !== 1'b1) dropped = 1'b1;
    end
    n_chk++;
    if (dropped) begin
      n_fail++;
      $display("FAIL ur_pre_hold: got core_reset low before count 2000 required high");
    end
    user_reset = 1'b1;
    tick;
    user_reset = 1'b0;
    n = 0;
    while (core_reset === 1'b1 && n < 6000) begin
      n++;
      tick;
    end
    n_chk++;
    if (n != N) begin
      n_fail++;
      $display("FAIL ur_restart_len: got %0d cycles required %0d", n, N);
    end
    n_chk++;
    if (rom_err !== 1'b1 || load_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ur_run: got rom_err=%b busy=%b required 1/0", rom_err, load_busy);
    end
    user_reset = 1'b1;
    tick;
    user_reset = 1'b0;
    dropped = core_reset !== 1'b1;
    repeat (100) begin
      tick;
      if (core_reset !== 1'b1) dropped = 1'b1;
    end
    n_chk++;
    if (dropped) begin
      n_fail++;
      $display("FAIL ur_run_restart: got core_reset low in restarted settle required high");
    end
    start_dl(8'd0);
    n_chk++;
    if (load_busy !== 1'b1 || rom_err !== 1'b0 || core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL ur_abort_load: got busy=%b err=%b core_reset=%b required 1/0/1", load_busy, rom_err, core_reset);
    end
    end_dl;
  endtask
  task automatic test_fall_wr;
    exp_q.delete();
    got_q.delete();
    start_dl(8'd0);
    put_byte(8'd0, 25'd10, 8'h77);
    put_byte(8'd0, 25'd11, 8'h78);
    ioctl_download = 1'b0;
    put_byte(8'd0, 25'd5, 8'h33);
    n_chk++;
    if (rom_wr !== 1'b0 || load_busy !== 1'b0 || core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_wr: got rom_wr=%b busy=%b core_reset=%b required 0/0/1", rom_wr, load_busy, core_reset);
    end
    tick;
    n_chk++;
    if (got_q.size() != exp_q.size() || rom_addr !== 16'd11 || rom_data !== 8'h78) begin
      n_fail++;
      $display("FAIL fall_wr_hold: got %0d writes %h/%h required %0d writes 000b/78", got_q.size(),
               rom_addr, rom_data, exp_q.size());
    end
  endtask
  task automatic test_reset_mid;
    start_dl(8'd0);
    put_byte(8'd0, 25'h1234, 8'hAB);
    reset_n = 1'b0;
    put_byte(8'd0, 25'd20, 8'h99);
    m_mod = '0;
    m_sw = '{8'hFF, 8'hFF, 8'hFF};
    m_err = 1'b0;
    n_chk++;
    if ({rom_wr, core_reset, load_busy, rom_err} !== 4'b0100 || rom_addr !== 16'h0 || rom_data !== 8'h0) begin
      n_fail++;
      $display("FAIL mid_reset_out: got wr/cr/busy/err=%b %h/%h required 0100 0000/00",
               {rom_wr, core_reset, load_busy, rom_err}, rom_addr, rom_data);
    end
    n_chk++;
    if (mod_sel !== m_mod || sw !== {m_sw[2], m_sw[1], m_sw[0]}) begin
      n_fail++;
      $display("FAIL mid_reset_cfg: got %h/%h required 00/ffffff", mod_sel, sw);
    end
    tick;
    reset_n = 1'b1;
    tick;
    n_chk++;
    if (load_busy !== 1'b1 || core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_reload: got busy=%b core_reset=%b required 1/1", load_busy, core_reset);
    end
    end_dl;
  endtask
  initial begin
    test_reset;
    test_rom;
    test_regs;
    test_user_reset;
    test_fall_wr;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
